// File: rtl/sample_player_pkg.sv
// sample_player_pkg
// Shared constants and helpers for the sample_player replay engine.
//   S_PLAYER_IDLE / S_PLAYER_PLAY : player FSM encodings, also exported on
//                                   the debug_state port of sample_player.
//   sat_inc32                     : 32-bit saturating increment used by the
//                                   strobe counter.
package sample_player_pkg;

  localparam logic [0:0] S_PLAYER_IDLE = 1'b0;
  localparam logic [0:0] S_PLAYER_PLAY = 1'b1;

  // Holds at all-ones instead of wrapping, so a long looping run never makes
  // the count appear to restart.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// sample_ram
// Single-port-write / single-port-read sample store with a registered,
// read-first read port.
//   clock    : clock
//   reset    : synchronous, active-high; clears only the read data register,
//              the array contents are left alone
//   wr_en    : write strobe, wr_addr/wr_data written on the rising edge
//   rd_en    : read strobe, mem[rd_addr] captured into rd_data on the edge
//   rd_data  : last value read; holds while rd_en is low
// A read and a write to the same address in one cycle return the old data,
// because both use the pre-edge array contents.
module sample_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sample_player.sv
// sample_player
// IQ sample replay engine. A host preloads packed samples (I upper half,
// Q lower half) into the internal RAM; after start the player reads one
// sample every strobe_div+1 enabled cycles and presents it on sample_out
// with a one-cycle sample_out_strobe.
//
// Ports
//   clock, reset        : clock; synchronous active-high reset
//   enable              : global advance; low freezes every counter, the
//                         state and any pending strobe, and forces
//                         sample_out_strobe/done low
//   wr_en/wr_addr/wr_data : RAM load port, usable in any state
//   start, stop         : playback control pulses (stop wins when both high)
//   num_sample          : samples per pass, latched at start, clamped to the
//                         RAM depth; 0 makes start a no-op
//   strobe_div          : strobe period minus one, latched at start
//   loop_en             : wrap instead of finishing, latched at start
//   sample_out          : replayed sample, holds between strobes
//   sample_out_strobe   : sample_out valid for one cycle
//   busy                : playing, or a strobe still pending
//   done                : rides on the last strobe of a non-looping pass
//   sample_count        : strobes since the last start, saturating
//   debug_state         : current FSM state (S_PLAYER_IDLE / S_PLAYER_PLAY)
//
// Output handshake: sample_out_strobe is a valid with no ready. The consumer
// must take sample_out in every cycle the strobe is high; there is no
// back-pressure, the only way to pause the stream is enable.
//
// Build option: define SAMPLE_PLAYER_LOOP_EN to honour loop_en. Without it
// loop_en is ignored and the wrap path is not built.
module sample_player
  import sample_player_pkg::*;
#(
  parameter int IQ_WIDTH   = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [2*IQ_WIDTH-1:0]   wr_data,
  input  logic                    start,
  input  logic                    stop,
  input  logic [ADDR_WIDTH:0]     num_sample,
  input  logic [DIV_WIDTH-1:0]    strobe_div,
  input  logic                    loop_en,
  output logic [2*IQ_WIDTH-1:0]   sample_out,
  output logic                    sample_out_strobe,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             sample_count,
  output logic [0:0]              debug_state
);

  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] NUM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DIV_WIDTH-1:0]  div_cnt;
  logic [DIV_WIDTH-1:0]  div_lat;
  logic [ADDR_WIDTH:0]   num_lat;
  // pending: a RAM read was issued on the last enabled cycle, so its data
  // sits in the RAM read register waiting to be strobed out.
  logic                  pending;
  logic                  pending_done;
  logic                  loop_active;

  logic                  playing;
  logic                  start_go;
  logic                  tick;
  logic                  tick_fire;
  logic                  last_tick;
  logic [ADDR_WIDTH:0]   num_clamped;

  assign playing     = (state == S_PLAYER_PLAY);
  assign start_go    = !playing && start && !stop && (num_sample != '0);
  assign num_clamped = (num_sample > DEPTH) ? DEPTH : num_sample;
  assign tick        = playing && (div_cnt == div_lat);
  // A tick coinciding with stop is dropped: no read, no strobe, no count.
  assign tick_fire   = tick && !stop;
  assign last_tick   = ({1'b0, rd_addr} == (num_lat - NUM_ONE));

`ifdef SAMPLE_PLAYER_LOOP_EN
  logic loop_lat;

  always_ff @(posedge clock) begin
    if (reset) begin
      loop_lat <= 1'b0;
    end else if (enable && start_go) begin
      loop_lat <= loop_en;
    end
  end

  assign loop_active = loop_lat;
`else
  logic unused_loop_en;

  assign unused_loop_en = loop_en;
  assign loop_active    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_PLAYER_IDLE;
      rd_addr      <= '0;
      div_cnt      <= '0;
      div_lat      <= '0;
      num_lat      <= '0;
      pending      <= 1'b0;
      pending_done <= 1'b0;
      sample_count <= '0;
    end else if (enable) begin
      pending      <= tick_fire;
      pending_done <= tick_fire && last_tick && !loop_active;

      if (start_go) begin
        state        <= S_PLAYER_PLAY;
        rd_addr      <= '0;
        div_cnt      <= '0;
        div_lat      <= strobe_div;
        num_lat      <= num_clamped;
        sample_count <= '0;
      end else if (playing) begin
        if (stop) begin
          state <= S_PLAYER_IDLE;
        end else if (tick) begin
          div_cnt <= '0;
          // Counted at the tick so the new value is visible together with
          // the strobe it belongs to.
          sample_count <= sat_inc32(sample_count);
          if (last_tick) begin
            rd_addr <= '0;
            if (!loop_active) begin
              state <= S_PLAYER_IDLE;
            end
          end else begin
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
          end
        end else begin
          div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
      end
    end
  end

  // The RAM read register is the sample_out register: the read issued on a
  // tick lands on the next edge, which is exactly the strobe cycle.
  sample_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (2*IQ_WIDTH)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (enable && tick_fire),
    .rd_addr (rd_addr),
    .rd_data (sample_out)
  );

  assign sample_out_strobe = enable && pending;
  assign done              = enable && pending && pending_done;
  assign busy              = playing || pending;
  assign debug_state       = state;

endmodule

// File: tb/tb_sample_player.sv
`timescale 1ns/1ps
module tb_sample_player;
  import sample_player_pkg::*;

  localparam int IQ_WIDTH   = 16;
  localparam int ADDR_WIDTH = 6;
  localparam int DIV_WIDTH  = 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int DW         = 2*IQ_WIDTH;

  // ---------------- clock / reset / DUT ----------------
  logic                  clock = 1'b0;
  logic                  reset;
  logic                  enable;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DW-1:0]         wr_data;
  logic                  start;
  logic                  stop;
  logic [ADDR_WIDTH:0]   num_sample;
  logic [DIV_WIDTH-1:0]  strobe_div;
  logic                  loop_en;
  logic [DW-1:0]         sample_out;
  logic                  sample_out_strobe;
  logic                  busy;
  logic                  done;
  logic [31:0]           sample_count;
  logic [0:0]            debug_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  sample_player #(
    .IQ_WIDTH   (IQ_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIV_WIDTH  (DIV_WIDTH)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .start             (start),
    .stop              (stop),
    .num_sample        (num_sample),
    .strobe_div        (strobe_div),
    .loop_en           (loop_en),
    .sample_out        (sample_out),
    .sample_out_strobe (sample_out_strobe),
    .busy              (busy),
    .done              (done),
    .sample_count      (sample_count),
    .debug_state       (debug_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0]   cyc;
    logic [31:0]   count;
    logic          done;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mem_m [DEPTH];
  int            checks = 0;
  int            passes = 0;
  int            model_count = 0;
  logic          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (sample_out_strobe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_cycle", 64'(cyc), 64'(e.cyc));
          check("strobe_data", 64'(sample_out), 64'(e.data));
          check("strobe_done", 64'(done), 64'(e.done));
          check("strobe_count", 64'(sample_count), 64'(e.count));
        end
      end else if (done) begin
        check("done_without_strobe", 64'd1, 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_mem(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = ADDR_WIDTH'(a);
    wr_data = d;
    step();
    wr_en   = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) write_mem(k, $urandom());
  endtask

  // One playback run. stop_tick: index of the tick that coincides with stop
  // (-1: none). drop_idx: strobe index at which enable goes low for 7 cycles
  // (-1: none). wr_tick: tick index during which that sample's address is
  // overwritten (-1: none).
  task automatic run_play(input int n, input int sd, input bit lp,
                          input int stop_tick, input int drop_idx, input int wr_tick);
    int  neff, nstrobe, t0, last_off, e_off, off;
    bit  looping, wrote;
    neff = (n > DEPTH) ? DEPTH : n;
`ifdef SAMPLE_PLAYER_LOOP_EN
    looping = lp;
`else
    looping = 1'b0;
`endif
    if (neff == 0) nstrobe = 0;
    else if (stop_tick >= 0 && (looping || stop_tick < neff)) nstrobe = stop_tick;
    else nstrobe = neff;

    t0    = cyc;
    e_off = 2 + sd + drop_idx*(sd+1);
    for (int k = 0; k < nstrobe; k++) begin
      exp_t e;
      off = 2 + sd + k*(sd+1);
      if (drop_idx >= 0 && k >= drop_idx) off += 7;
      e.cyc   = 32'(t0 + off);
      e.data  = mem_m[k % neff];
      e.done  = !looping && (k == neff-1);
      e.count = 32'(k + 1);
      exp_q.push_back(e);
    end
    last_off = 2 + sd + ((nstrobe > 0) ? nstrobe-1 : 2)*(sd+1) + ((drop_idx >= 0) ? 7 : 0);

    num_sample = (ADDR_WIDTH+1)'(n);
    strobe_div = DIV_WIDTH'(sd);
    loop_en    = lp;
    for (int r = 0; r <= last_off + 2; r++) begin
      start  = (r == 0);
      stop   = (stop_tick >= 0) && (r == 1 + sd + stop_tick*(sd+1));
      enable = !(drop_idx >= 0 && r >= e_off && r < e_off + 7);
      wrote  = (wr_tick >= 0) && (r == 1 + sd + wr_tick*(sd+1));
      if (wrote) begin
        wr_en   = 1'b1;
        wr_addr = ADDR_WIDTH'(wr_tick);
        wr_data = ~mem_m[wr_tick];
      end else begin
        wr_en = 1'b0;
      end
      step();
      if (wrote) mem_m[wr_tick] = wr_data;
      if (r == 0) check("busy_after_start", 64'(busy), 64'(neff > 0));
    end
    start  = 1'b0;
    stop   = 1'b0;
    wr_en  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    if (neff > 0) model_count = nstrobe;
    check("busy_after_run", 64'(busy), 64'd0);
    check("count_after_run", 64'(sample_count), 64'(model_count));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    reset = 1'b1; enable = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; num_sample = '0; strobe_div = '0; loop_en = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    check("reset_sample_out", 64'(sample_out), 64'd0);
    check("reset_strobe", 64'(sample_out_strobe), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_count", 64'(sample_count), 64'd0);
    check("reset_state", 64'(debug_state), 64'(S_PLAYER_IDLE));
    mon_en = 1'b1;

    // Basic pass: 10 samples, period 5.
    for (int k = 0; k < 10; k++) write_mem(k, 32'h0001_0002 + 32'(k));
    run_play(10, 4, 1'b0, -1, -1, -1);

    // Full depth, back-to-back strobes.
    fill_random(DEPTH);
    run_play(DEPTH, 0, 1'b0, -1, -1, -1);

    // Stop coinciding with the 4th tick.
    run_play(8, 2, 1'b0, 3, -1, -1);

    // start and stop together: nothing happens.
    num_sample = 5; strobe_div = 1; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", 64'(busy), 64'd0);
    repeat (15) step();
    check("start_stop_busy_later", 64'(busy), 64'd0);

    // enable low for 7 cycles between a tick and its strobe.
    run_play(6, 4, 1'b0, -1, 2, -1);

    // Read-first: overwrite the address being read in the same cycle.
    run_play(10, 3, 1'b0, -1, -1, 4);

    // Loop request (honoured only when the loop build option is on).
    run_play(3, 1, 1'b1, 8, -1, -1);
    loop_en = 1'b0;

    // num_sample = 0 is ignored.
    run_play(0, 2, 1'b0, -1, -1, -1);

    // Random runs, including num_sample above the depth (clamped).
    for (int i = 0; i < 4; i++) begin
      fill_random(DEPTH);
      run_play($urandom_range(1, 2*DEPTH-1), $urandom_range(0, 5), 1'b0, -1, -1, -1);
    end

    // Reset in the middle of playback.
    fill_random(20);
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.cyc = 32'(t0 + 3 + 2*k); e.data = mem_m[k]; e.done = 1'b0; e.count = 32'(k + 1);
      exp_q.push_back(e);
    end
    num_sample = 20; strobe_div = 1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_sample_out", 64'(sample_out), 64'd0);
    check("midreset_strobe", 64'(sample_out_strobe), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_count", 64'(sample_count), 64'd0);
    check("midreset_queue", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (10) step();
    check("midreset_busy_later", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
